vx_perf_pipeline_counters: RTL and testbench

Per-core pipeline performance counter bank with a CSR readout sequencer. It accumulates per-cycle event strobes from decode and issue into wrapping counters and exports them as a flat bus for the pipeline perf interface. It also serves 32-bit CSR reads through a valid/ready request/response handshake, with a lo-half snapshot so that a following hi-half read returns a consistent 64-bit value. It sits between the decode/issue stages and the core's CSR unit.

---
 rtl/vx_perf_pipeline_counters.sv | 173 +++++++++++++++++
 tb/tb_vx_perf_pipeline_counters.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_perf_pipeline_counters.sv
// Per-core pipeline performance counter bank.
// Eleven wrapping event counters fed by decode/issue strobes, exported live on
// ctr_flat, plus a two-state CSR read sequencer. A lo-half read snapshots the
// upper bits of the same counter so that the following hi-half read returns a
// value consistent with the lo half, even if the counter carried in between.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_RESP | response registered in rsp_data; rsp_valid=1 until rsp_ready
module vx_perf_pipeline_counters #(
    parameter int CTR_BITS    = 44,
    parameter int NUM_THREADS = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               clear,
    input  logic                               ev_load,
    input  logic                               ev_store,
    input  logic                               ev_branch,
    input  logic                               ev_ibf,
    input  logic                               ev_scb,
    input  logic                               ev_lsu,
    input  logic                               ev_csr,
    input  logic                               ev_alu,
    input  logic                               ev_fpu,
    input  logic                               ev_gpu,
    input  logic                               active_valid,
    input  logic [$clog2(NUM_THREADS+1)-1:0]   active_cnt,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [3:0]                         req_idx,
    input  logic                               req_hi,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [31:0]                        rsp_data,
    output logic [11*CTR_BITS-1:0]             ctr_flat
);

    localparam int NUM_CTRS = 11;
    localparam int HI_BITS  = CTR_BITS - 32;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    // Single-bit strobes in counter order, skipping index 3 (active threads).
    logic [9:0] ev_vec;
    assign ev_vec = {ev_gpu, ev_fpu, ev_alu, ev_csr, ev_lsu,
                     ev_scb, ev_ibf, ev_branch, ev_store, ev_load};

    logic [CTR_BITS-1:0] ctr_val [NUM_CTRS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRS; gi++) begin : gen_ctr
            logic [CTR_BITS-1:0] cnt;
            logic [CTR_BITS-1:0] inc;

            if (gi == 3) begin : g_active
                assign inc = active_valid ? CTR_BITS'(active_cnt) : '0;
            end else if (gi < 3) begin : g_dec
                assign inc = CTR_BITS'(ev_vec[gi]);
            end else begin : g_iss
                assign inc = CTR_BITS'(ev_vec[gi-1]);
            end

            // Wrapping accumulate; clear wins over increment, enable low holds.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + inc;
                end
            end

            assign ctr_val[gi]                          = cnt;
            assign ctr_flat[gi*CTR_BITS +: CTR_BITS]    = cnt;
        end
    endgenerate

    logic [CTR_BITS-1:0] sel_ctr;
    logic [HI_BITS-1:0]  sel_hi;
    logic                idx_valid;
    logic [HI_BITS-1:0]  shadow_q;
    logic [3:0]          shadow_idx;
    logic                shadow_vld;
    logic [31:0]         rd_data;
    logic [31:0]         rsp_data_q;
    logic                accept;

    // Select the addressed counter; unmapped indices read as zero.
    always_comb begin
        sel_ctr = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (req_idx == 4'(i)) begin
                sel_ctr = ctr_val[i];
            end
        end
    end

    assign idx_valid = (req_idx < 4'(NUM_CTRS));
    assign sel_hi    = sel_ctr[CTR_BITS-1:32];

    // Hi reads prefer the snapshot taken by a preceding lo read of the same index.
    always_comb begin
        rd_data = sel_ctr[31:0];
        if (req_hi) begin
            if (shadow_vld && (shadow_idx == req_idx)) begin
                rd_data = 32'(shadow_q);
            end else begin
                rd_data = 32'(sel_hi);
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Read sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one request in flight at a time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture read data at accept; it stays frozen until the response drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data_q <= '0;
        end else if (accept) begin
            rsp_data_q <= rd_data;
        end
    end

    // Upper-half snapshot on lo reads; clear invalidates it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= '0;
            shadow_idx <= '0;
            shadow_vld <= 1'b0;
        end else if (clear) begin
            shadow_vld <= 1'b0;
        end else if (accept && !req_hi && idx_valid) begin
            shadow_q   <= sel_hi;
            shadow_idx <= req_idx;
            shadow_vld <= 1'b1;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vx_perf_pipeline_counters.sv
// Bench for vx_perf_pipeline_counters: a cycle model of the counters, shadow
// and read sequencer predicts each response into a queue at accept time; the
// queue head is compared whenever the DUT presents a response.
module tb_vx_perf_pipeline_counters;

    localparam int CB = 33;
    localparam int NT = 4;
    localparam int AW = $clog2(NT + 1);
    localparam int NC = 11;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic          ev_load, ev_store, ev_branch;
    logic          ev_ibf, ev_scb, ev_lsu, ev_csr, ev_alu, ev_fpu, ev_gpu;
    logic          active_valid;
    logic [AW-1:0] active_cnt;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_idx;
    logic          req_hi;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [11*CB-1:0] ctr_flat;

    vx_perf_pipeline_counters #(.CTR_BITS(CB), .NUM_THREADS(NT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .ev_load(ev_load), .ev_store(ev_store), .ev_branch(ev_branch),
        .ev_ibf(ev_ibf), .ev_scb(ev_scb), .ev_lsu(ev_lsu), .ev_csr(ev_csr),
        .ev_alu(ev_alu), .ev_fpu(ev_fpu), .ev_gpu(ev_gpu),
        .active_valid(active_valid), .active_cnt(active_cnt),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_hi(req_hi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .ctr_flat(ctr_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [CB-1:0]  model [NC];
    logic           m_idle;
    logic [CB-33:0] m_shadow;
    logic [3:0]     m_sidx;
    logic           m_svld;
    logic [31:0]    exp_q [$];
    logic [31:0]    last_data;
    int             errors;
    int             checks;
    int             nrsp;
    int             n0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CB-1:0] dctr(input int i);
        return ctr_flat[i*CB +: CB];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) model[i] = '0;
        m_idle = 1'b1;
        m_svld = 1'b0;
        m_shadow = '0;
        m_sidx = '0;
        exp_q.delete();
    endtask

    task automatic check_all();
        for (int i = 0; i < NC; i++) chk($sformatf("ctr%0d", i), dctr(i), model[i]);
    endtask

    // Observe handshake and response against the model's view of the sequencer.
    task automatic monitor();
        chk("req_ready", req_ready, m_idle);
        chk("rsp_valid", rsp_valid, !m_idle);
        if (rsp_valid) begin
            chk("rsp_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                chk($sformatf("rsp_data_idx%0d", req_idx), rsp_data, exp_q[0]);
                if (rsp_ready) begin
                    last_data = rsp_data;
                    void'(exp_q.pop_front());
                    nrsp++;
                end
            end
        end
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic model_step();
        logic [CB-1:0] v;
        logic [31:0]   d;
        logic          evs [NC];
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_idle && req_valid) begin
            v = (int'(req_idx) < NC) ? model[int'(req_idx)] : '0;
            if (req_hi) begin
                d = (m_svld && m_sidx == req_idx) ? 32'(m_shadow) : 32'(v[CB-1:32]);
            end else begin
                d = v[31:0];
                if (int'(req_idx) < NC) begin
                    m_shadow = v[CB-1:32];
                    m_sidx = req_idx;
                    m_svld = 1'b1;
                end
            end
            exp_q.push_back(d);
            m_idle = 1'b0;
        end else if (!m_idle && rsp_ready) begin
            m_idle = 1'b1;
        end
        evs[0] = ev_load;  evs[1] = ev_store; evs[2] = ev_branch; evs[3] = 1'b0;
        evs[4] = ev_ibf;   evs[5] = ev_scb;   evs[6] = ev_lsu;    evs[7] = ev_csr;
        evs[8] = ev_alu;   evs[9] = ev_fpu;   evs[10] = ev_gpu;
        if (clear) begin
            for (int i = 0; i < NC; i++) model[i] = '0;
            m_svld = 1'b0;
        end else if (enable) begin
            for (int i = 0; i < NC; i++) begin
                if (i == 3) begin
                    if (active_valid) model[i] = model[i] + CB'(active_cnt);
                end else if (evs[i]) begin
                    model[i] = model[i] + 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_strobes(input logic v);
        ev_load = v; ev_store = v; ev_branch = v;
        ev_ibf = v; ev_scb = v; ev_lsu = v; ev_csr = v;
        ev_alu = v; ev_fpu = v; ev_gpu = v;
    endtask

    task automatic read(input logic [3:0] idx, input logic hi, input int hold);
        req_valid = 1'b1;
        req_idx = idx;
        req_hi = hi;
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; nrsp = 0; last_data = '0;
        model_reset();
        reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
        set_strobes(1'b1);
        active_valid = 1'b1; active_cnt = AW'(3);
        req_valid = 1'b0; req_idx = '0; req_hi = 1'b0; rsp_ready = 1'b0;

        repeat (3) tick();
        check_all();

        reset_n = 1'b1;
        repeat (5) tick();
        check_all();
        chk("load_after5", dctr(0), 5);
        chk("active_after5", dctr(3), 15);
        chk("gpu_after5", dctr(10), 5);

        enable = 1'b0;
        repeat (10) tick();
        chk("hold_load", dctr(0), 5);
        chk("hold_active", dctr(3), 15);
        check_all();

        read(4'd0, 1'b0, 0);
        chk("read0_lo", last_data, 5);
        read(4'd3, 1'b0, 1);
        chk("read3_lo", last_data, 15);
        read(4'd12, 1'b0, 0);
        chk("read12_lo", last_data, 0);
        read(4'd12, 1'b1, 0);
        read(4'd0, 1'b1, 0);

        enable = 1'b1;
        read(4'd8, 1'b0, 2);

        // Backpressure with a clear landing while the response is held.
        n0 = nrsp;
        req_valid = 1'b1; req_idx = 4'd1; req_hi = 1'b0;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        chk("bp_req_ready", req_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("bp_one_rsp", nrsp - n0, 1);
        check_all();

        // Wrap at 2^CB.
        set_strobes(1'b0); active_valid = 1'b0; enable = 1'b0;
        tick();
        force dut.gen_ctr[0].cnt = {CB{1'b1}};
        #1 release dut.gen_ctr[0].cnt;
        model[0] = {CB{1'b1}};
        tick();
        chk("wrap_pre", dctr(0), {CB{1'b1}});
        read(4'd0, 1'b1, 0);
        chk("wrap_pre_hi", last_data, 1);
        enable = 1'b1; ev_load = 1'b1;
        tick();
        ev_load = 1'b0;
        tick();
        chk("wrap_zero", dctr(0), 0);
        read(4'd0, 1'b1, 0);
        chk("wrap_hi", last_data, 0);

        // Snapshot across a carry into the upper half.
        ev_lsu = 1'b1;
        force dut.gen_ctr[6].cnt = 33'h0_FFFF_FFFF;
        force dut.gen_ctr[7].cnt = 33'h1_0000_0005;
        #1;
        release dut.gen_ctr[6].cnt;
        release dut.gen_ctr[7].cnt;
        model[6] = 33'h0_FFFF_FFFF;
        model[7] = 33'h1_0000_0005;
        read(4'd6, 1'b0, 0);
        chk("snap_lo", last_data, 32'hFFFF_FFFF);
        read(4'd6, 1'b1, 0);
        chk("snap_hi", last_data, 0);
        chk("snap_live_upper", dctr(6) >> 32, 1);
        read(4'd7, 1'b1, 0);
        chk("idx7_hi", last_data, 1);
        check_all();

        // Reset in the middle of a held response.
        ev_lsu = 1'b0; enable = 1'b0;
        req_valid = 1'b1; req_idx = 4'd0; req_hi = 1'b0;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
        check_all();
        read(4'd6, 1'b0, 0);
        chk("post_rst_read", last_data, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
